// File: rtl/ult_effect_arbiter.sv
// Arbitrates the shared full-screen ultimate effect between two players:
// round-robin grant pulse, timed effect window, then optional cooldown.
module ult_effect_arbiter #(
  parameter int unsigned EFFECT_CYCLES   = 50000000,
  parameter int unsigned COOLDOWN_CYCLES = 10000000,
  parameter int unsigned CNT_W           = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p1_req,
  input  logic       p2_req,
  input  logic       p1_alive,
  input  logic       p2_alive,
  output logic       p1_grant,
  output logic       p2_grant,
  output logic       effect_active,
  output logic [1:0] effect_owner,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    ACTIVE   = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] EFF_LOAD  = CNT_W'(EFFECT_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);
  localparam bit               NO_COOL   = (COOLDOWN_CYCLES == 0);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             owner_p2, owner_p2_n;
  logic             last_p2, last_p2_n;
  logic             elig1, elig2, win_p2, owner_alive;
  logic             p1_grant_n, p2_grant_n, effect_active_n, busy_n;
  logic [1:0]       effect_owner_n;

  // Next-state, counter and next-output decode
  always_comb begin
    state_n         = state;
    cnt_n           = cnt;
    owner_p2_n      = owner_p2;
    last_p2_n       = last_p2;
    elig1           = p1_req & p1_alive;
    elig2           = p2_req & p2_alive;
    // On a tie the player who did not win last time takes it
    win_p2          = elig2 & (~elig1 | ~last_p2);
    owner_alive     = owner_p2 ? p2_alive : p1_alive;

    case (state)
      IDLE: begin
        if (elig1 | elig2) begin
          state_n    = GRANT;
          owner_p2_n = win_p2;
          last_p2_n  = win_p2;
          cnt_n      = EFF_LOAD;
        end
      end
      GRANT: state_n = ACTIVE;
      ACTIVE: begin
        // Natural end or owner death both drop straight into the lockout
        if (cnt == '0 || !owner_alive) begin
          if (NO_COOL) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            state_n = COOLDOWN;
            cnt_n   = COOL_LOAD;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      COOLDOWN: begin
        if (cnt == '0) state_n = IDLE;
        else           cnt_n   = cnt - CNT_W'(1);
      end
      default: state_n = IDLE;
    endcase

    p1_grant_n      = (state_n == GRANT) & ~owner_p2_n;
    p2_grant_n      = (state_n == GRANT) &  owner_p2_n;
    effect_active_n = (state_n == ACTIVE);
    effect_owner_n  = effect_active_n ? (owner_p2_n ? 2'b10 : 2'b01) : 2'b00;
    busy_n          = (state_n != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      owner_p2      <= 1'b0;
      last_p2       <= 1'b1;
      p1_grant      <= 1'b0;
      p2_grant      <= 1'b0;
      effect_active <= 1'b0;
      effect_owner  <= 2'b00;
      busy          <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      owner_p2      <= owner_p2_n;
      last_p2       <= last_p2_n;
      p1_grant      <= p1_grant_n;
      p2_grant      <= p2_grant_n;
      effect_active <= effect_active_n;
      effect_owner  <= effect_owner_n;
      busy          <= busy_n;
    end
  end

endmodule

// File: tb/tb_ult_effect_arbiter.sv
// Bench for ult_effect_arbiter: two instances (cooldown 2 and 0) against an
// interval-based timeline model, plus directed literal scenarios.
module tb_ult_effect_arbiter;

  localparam int E  = 4;
  localparam int CA = 2;
  localparam int CB = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic p1_req = 1'b0, p2_req = 1'b0, p1_alive = 1'b1, p2_alive = 1'b1;
  logic a_g1, a_g2, a_act, a_busy;
  logic b_g1, b_g2, b_act, b_busy;
  logic [1:0] a_own, b_own;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ult_effect_arbiter #(.EFFECT_CYCLES(E), .COOLDOWN_CYCLES(CA), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .p1_req(p1_req), .p2_req(p2_req),
    .p1_alive(p1_alive), .p2_alive(p2_alive), .p1_grant(a_g1), .p2_grant(a_g2),
    .effect_active(a_act), .effect_owner(a_own), .busy(a_busy));

  ult_effect_arbiter #(.EFFECT_CYCLES(E), .COOLDOWN_CYCLES(CB), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .p1_req(p1_req), .p2_req(p2_req),
    .p1_alive(p1_alive), .p2_alive(p2_alive), .p1_grant(b_g1), .p2_grant(b_g2),
    .effect_active(b_act), .effect_owner(b_own), .busy(b_busy));

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Timeline model: each grant is described by its grant edge, the last edge
  // that shows the effect, and the edge from which the arbiter is idle again.
  int k = 0;
  int m_g[2], m_al[2], m_ie[2], m_own[2], m_lw[2];

  task automatic model_rst(input int i);
    m_g[i] = -100; m_al[i] = -100; m_ie[i] = -100; m_own[i] = 0; m_lw[i] = 2;
  endtask

  task automatic model_step(input int i);
    int c = (i == 0) ? CA : CB;
    bit e1 = p1_req && p1_alive;
    bit e2 = p2_req && p2_alive;
    int w = 0;
    bit oa;
    if (k > m_ie[i]) begin
      if (e1 && e2) w = (m_lw[i] == 2) ? 1 : 2;
      else if (e1)  w = 1;
      else if (e2)  w = 2;
      if (w != 0) begin
        m_own[i] = w; m_lw[i] = w; m_g[i] = k;
        m_al[i] = k + E; m_ie[i] = k + E + c + 1;
      end
    end else if (k - 1 > m_g[i] && k - 1 < m_al[i]) begin
      oa = (m_own[i] == 1) ? p1_alive : p2_alive;
      if (!oa) begin
        m_al[i] = k - 1; m_ie[i] = k + c;
      end
    end
  endtask

  task automatic compare(input int i);
    logic g1, g2, ac, bz;
    logic [1:0] ow;
    bit eact;
    if (i == 0) begin g1 = a_g1; g2 = a_g2; ac = a_act; bz = a_busy; ow = a_own; end
    else        begin g1 = b_g1; g2 = b_g2; ac = b_act; bz = b_busy; ow = b_own; end
    eact = (k > m_g[i]) && (k <= m_al[i]);
    chk($sformatf("m_grant1_%0d", i), int'(g1), int'(k == m_g[i] && m_own[i] == 1));
    chk($sformatf("m_grant2_%0d", i), int'(g2), int'(k == m_g[i] && m_own[i] == 2));
    chk($sformatf("m_active_%0d", i), int'(ac), int'(eact));
    chk($sformatf("m_owner_%0d", i), int'(ow), eact ? m_own[i] : 0);
    chk($sformatf("m_busy_%0d", i), int'(bz), int'(k < m_ie[i]));
    chk($sformatf("m_both_grant_%0d", i), int'(g1 && g2), 0);
  endtask

  // Single compare process: model advance on each edge, check 1 time unit later
  always @(posedge clk) begin
    if (reset) begin
      model_rst(0); model_rst(1);
    end else begin
      k++;
      model_step(0); model_step(1);
    end
    #1;
    compare(0); compare(1);
  end

  int qa[$], qb[$];

  task automatic run_log(input int n);
    qa.delete(); qb.delete();
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #2;
      if (a_g1) qa.push_back(c * 10 + 1);
      if (a_g2) qa.push_back(c * 10 + 2);
      if (b_g1) qb.push_back(c * 10 + 1);
      if (b_g2) qb.push_back(c * 10 + 2);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; p1_req = 1'b0; p2_req = 1'b0; p1_alive = 1'b1; p2_alive = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    @(negedge clk);
    p1_req = 1'b0; p2_req = 1'b0; p1_alive = 1'b1; p2_alive = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int ea[3];
    int eb[3];
    repeat (2) @(posedge clk);
    #2;
    chk("rst_state_a", int'({a_g1, a_g2, a_act, a_busy, a_own}), 0);
    chk("rst_state_b", int'({b_g1, b_g2, b_act, b_busy, b_own}), 0);
    @(negedge clk); reset = 1'b0;

    // Single request
    @(negedge clk); p1_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #2;
      chk("s2_grant", int'(a_g1), int'(c == 1));
      chk("s2_active", int'(a_act), int'(c >= 2 && c <= 5));
      chk("s2_owner", int'(a_own), (c >= 2 && c <= 5) ? 1 : 0);
      chk("s2_busy", int'(a_busy), int'(c <= 7));
      @(negedge clk); p1_req = 1'b0;
    end

    // Tie with round-robin from reset
    do_reset();
    p1_req = 1'b1; p2_req = 1'b1;
    run_log(18);
    ea = '{11, 92, 171};
    eb = '{11, 72, 131};
    chk("s3_count_a", qa.size(), 3);
    chk("s3_count_b", qb.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < qa.size()) chk($sformatf("s3_a_%0d", i), qa[i], ea[i]);
      if (i < qb.size()) chk($sformatf("s3_b_%0d", i), qb[i], eb[i]);
    end
    idle_cycles(10);

    // Zero cooldown with p1 held
    do_reset();
    p1_req = 1'b1;
    run_log(14);
    eb = '{11, 71, 131};
    chk("s6_count_b", qb.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < qb.size()) chk($sformatf("s6_b_%0d", i), qb[i], eb[i]);
    chk("s6_count_a", qa.size(), 2);
    idle_cycles(10);

    // Dead requester
    @(negedge clk); p1_req = 1'b1; p1_alive = 1'b0;
    run_log(20);
    chk("s4_dead_a", qa.size(), 0);
    chk("s4_dead_b", qb.size(), 0);
    idle_cycles(2);

    // Owner dies in its 2nd active cycle
    @(negedge clk); p2_req = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #2;
      chk("s4_grant2", int'(a_g2), int'(c == 1));
      chk("s4_active", int'(a_act), int'(c == 2 || c == 3));
      chk("s4_owner", int'(a_own), (c == 2 || c == 3) ? 2 : 0);
      chk("s4_busy", int'(a_busy), int'(c <= 5));
      @(negedge clk); p2_req = 1'b0;
      if (c == 3) p2_alive = 1'b0;
    end
    idle_cycles(4);

    // Request pulse during a busy window is dropped
    @(negedge clk); p1_req = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #2;
      chk("s5_grant1", int'(a_g1), int'(c == 1));
      chk("s5_no_grant2_a", int'(a_g2), 0);
      chk("s5_no_grant2_b", int'(b_g2), 0);
      @(negedge clk); p1_req = 1'b0; p2_req = (c == 3);
    end
    idle_cycles(4);

    // Asynchronous reset mid-effect
    @(negedge clk); p1_req = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("s1_pre_active", int'(a_act), 1);
    #1; reset = 1'b1; p1_req = 1'b0;
    #1;
    chk("s1_rst_a", int'({a_g1, a_g2, a_act, a_busy, a_own}), 0);
    chk("s1_rst_b", int'({b_g1, b_g2, b_act, b_busy, b_own}), 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0; p2_req = 1'b1;
    @(posedge clk); #2;
    chk("s1_after_a", int'(a_g2), 1);
    chk("s1_after_b", int'(b_g2), 1);
    idle_cycles(10);

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      p1_req   = ($urandom_range(0, 99) < 40);
      p2_req   = ($urandom_range(0, 99) < 40);
      p1_alive = ($urandom_range(0, 99) < 93);
      p2_alive = ($urandom_range(0, 99) < 93);
      reset    = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk); reset = 1'b0;
    idle_cycles(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ult_effect_arbiter.md
# ult_effect_arbiter

Arbitrates the single full-screen ultimate-effect resource between the two players. It accepts level ult requests (keyboard key AND ult-ready from the LED meter logic), grants one player at a time with round-robin tie-breaking, and issues a one-cycle grant pulse that clears that player's ult meter. It then times the effect window and a cooldown window. It sits between the keyboard/ult-meter logic and the OLED effect renderer, and its grant pulses replace the direct `keyboard & ult_ready` clear path.

## Interface
Parameters:
- `EFFECT_CYCLES`, default 50000000: effect window length in `clk` cycles; must be ≥1.
- `COOLDOWN_CYCLES`, default 10000000: post-effect lockout in `clk` cycles; 0 is legal and means no cooldown.
- `CNT_W`, default 32: width of the shared down-counter.

Ports:
- `clk`, input, 1: system clock (100 MHz).
- `reset`, input, 1: asynchronous, active-high reset.
- `p1_req`, input, 1: player 1 ult request, level.
- `p2_req`, input, 1: player 2 ult request, level.
- `p1_alive`, input, 1: player 1 health is nonzero.
- `p2_alive`, input, 1: player 2 health is nonzero.
- `p1_grant`, output, 1: one-cycle pulse that clears player 1's meter.
- `p2_grant`, output, 1: one-cycle pulse that clears player 2's meter.
- `effect_active`, output, 1: high during the effect window.
- `effect_owner`, output, 2: 00 = none, 01 = P1, 10 = P2; valid while `effect_active` is high, otherwise 00.
- `busy`, output, 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, GRANT, ACTIVE, COOLDOWN. All outputs are registered.
- Reset:
  - State goes to IDLE; counter = 0.
  - All outputs are 0.
  - Internal `last_winner` = P2, so player 1 wins the first tie.
- IDLE:
  - A request is eligible only when `pN_req && pN_alive`.
  - One eligible request: that player wins.
  - Both eligible: the player that is not `last_winner` wins.
  - On a win: go to GRANT, set the owner, update `last_winner`, load counter = EFFECT_CYCLES−1.
  - No eligible request: stay in IDLE.
- GRANT: exactly one cycle. The winner's `pN_grant` = 1 and `busy` = 1. Next state is ACTIVE.
- ACTIVE:
  - `effect_active` = 1 and `effect_owner` = winner. The counter decrements each cycle.
  - Counter == 0: go to COOLDOWN with counter loaded to COOLDOWN_CYCLES−1. If COOLDOWN_CYCLES == 0, go directly to IDLE.
  - Owner's `alive` drops: abort. Go to COOLDOWN (or IDLE if COOLDOWN_CYCLES == 0) on the next edge; the remaining effect count is discarded.
- COOLDOWN: `busy` = 1. The counter decrements; when it reaches 0, go to IDLE.
- Requests arriving in any non-IDLE state are ignored and not queued. A requester that is still asserting when the FSM re-enters IDLE is arbitrated normally.
- A grant is never issued to a dead player, even if that player's request is high.
- Reset asserted mid-operation: return immediately (asynchronously) to the reset state. Any grant pulse in flight is dropped.

## Timing
- Request sampled high in IDLE at edge n:
  - `pN_grant` is high for cycle n+1 only.
  - `effect_active` is high for cycles n+2 through n+1+EFFECT_CYCLES.
  - COOLDOWN occupies the next COOLDOWN_CYCLES cycles.
  - IDLE is reached at n+2+EFFECT_CYCLES+COOLDOWN_CYCLES.
- Minimum grant-to-grant spacing is EFFECT_CYCLES+COOLDOWN_CYCLES+2 cycles.
- `busy` rises together with the grant pulse and falls on entry to IDLE.
- `p1_grant` and `p2_grant` are never high in the same cycle.
- The counter never wraps. The load value is always the parameter minus 1, and the counter is compared against 0 before decrementing.

## Test plan
All scenarios use EFFECT_CYCLES=4 and COOLDOWN_CYCLES=2 unless stated.
1. **Reset:** assert `reset` mid-ACTIVE → all outputs go to 0 immediately. After release, a `p2_req` is granted normally.
2. **Single request:** `p1_req`=1 from cycle 0 → `p1_grant` is high in cycle 1 only; `effect_active` is high in cycles 2–5 with `effect_owner`=01; `busy` falls at cycle 8.
3. **Tie and round-robin:** both requests held high continuously → grants go P1, P2, P1 with exactly 8 cycles between grants. `p1_grant` and `p2_grant` are never high together.
4. **Dead player and abort:**
   - `p1_req`=1 with `p1_alive`=0 → no grant ever.
   - P2 granted, then `p2_alive` drops in the 2nd ACTIVE cycle → `effect_active` is 0 on the next cycle, followed by 2 COOLDOWN cycles.
5. **Busy drop:** `p2_req` pulsed for 1 cycle during P1's ACTIVE window → no P2 grant afterwards.
6. **Zero cooldown:** COOLDOWN_CYCLES=0 with `p1_req` held → grants in cycles 1, 7, 13.
